// File: rtl/plot_arbiter.sv
// Pixel write arbiter for a VGA frame buffer: round-robin grants between the
// snake and food writers, plus a full-screen clear sweep that owns the port.
module plot_arbiter #(
    parameter int         WIDTH        = 160,
    parameter int         HEIGHT       = 120,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_start,
    input  logic       snake_req,
    input  logic [7:0] snake_x,
    input  logic [6:0] snake_y,
    input  logic [2:0] snake_colour,
    input  logic       food_req,
    input  logic [7:0] food_x,
    input  logic [6:0] food_y,
    input  logic [2:0] food_colour,
    output logic       snake_ack,
    output logic       food_ack,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour_out,
    output logic       plot,
    output logic       clear_busy,
    output logic       clear_done
);

    typedef enum logic {
        SERVE = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
    localparam logic [6:0] Y_LAST = 7'(HEIGHT - 1);
    localparam logic [8:0] X_LIM  = 9'(WIDTH);
    localparam logic [7:0] Y_LIM  = 8'(HEIGHT);

    state_t     state_r, state_s;
    logic [7:0] cx_r, cx_s;
    logic [6:0] cy_r, cy_s;
    logic       ptr_r, ptr_s;
    logic       grant_s, grant_snake_s;
    logic [7:0] sel_x_s;
    logic [6:0] sel_y_s;
    logic [2:0] sel_c_s;
    logic       pix_valid_s;
    logic [7:0] pix_x_s;
    logic [6:0] pix_y_s;
    logic [2:0] pix_c_s;
    logic       last_s;
    logic       busy_s;

    // Next-state, sweep counter, arbitration and pixel selection.
    always_comb begin
        state_s       = state_r;
        cx_s          = cx_r;
        cy_s          = cy_r;
        ptr_s         = ptr_r;
        grant_s       = 1'b0;
        grant_snake_s = 1'b0;
        snake_ack     = 1'b0;
        food_ack      = 1'b0;
        pix_valid_s   = 1'b0;
        pix_x_s       = x_out;
        pix_y_s       = y_out;
        pix_c_s       = colour_out;
        last_s        = 1'b0;
        sel_x_s       = snake_x;
        sel_y_s       = snake_y;
        sel_c_s       = snake_colour;

        if (rst) begin
            state_s = SERVE;
        end else begin
            case (state_r)
                SERVE: begin
                    if (clear_start) begin
                        state_s = CLEAR;
                        cx_s    = 8'd0;
                        cy_s    = 7'd0;
                    end else if (snake_req && food_req) begin
                        grant_s       = 1'b1;
                        grant_snake_s = ~ptr_r;
                        ptr_s         = ~ptr_r;
                    end else if (snake_req) begin
                        grant_s       = 1'b1;
                        grant_snake_s = 1'b1;
                    end else if (food_req) begin
                        grant_s       = 1'b1;
                        grant_snake_s = 1'b0;
                    end else begin
                        grant_s       = 1'b0;
                    end
                end
                CLEAR: begin
                    pix_valid_s = 1'b1;
                    pix_x_s     = cx_r;
                    pix_y_s     = cy_r;
                    pix_c_s     = CLEAR_COLOUR;
                    if (cx_r == X_LAST) begin
                        cx_s = 8'd0;
                        if (cy_r == Y_LAST) begin
                            cy_s    = 7'd0;
                            last_s  = 1'b1;
                            state_s = SERVE;
                        end else begin
                            cy_s = cy_r + 7'd1;
                        end
                    end else begin
                        cx_s = cx_r + 8'd1;
                    end
                end
                default: begin
                    state_s = SERVE;
                end
            endcase
        end

        if (grant_s) begin
            if (grant_snake_s) begin
                snake_ack = 1'b1;
                sel_x_s   = snake_x;
                sel_y_s   = snake_y;
                sel_c_s   = snake_colour;
            end else begin
                food_ack  = 1'b1;
                sel_x_s   = food_x;
                sel_y_s   = food_y;
                sel_c_s   = food_colour;
            end
            // Off-screen pixels are consumed but never written.
            if (({1'b0, sel_x_s} < X_LIM) && ({1'b0, sel_y_s} < Y_LIM)) begin
                pix_valid_s = 1'b1;
                pix_x_s     = sel_x_s;
                pix_y_s     = sel_y_s;
                pix_c_s     = sel_c_s;
            end else begin
                pix_valid_s = 1'b0;
            end
        end else begin
            grant_snake_s = 1'b0;
        end

        busy_s = (state_s == CLEAR);
    end

    // State, counters, pointer and registered VGA outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= SERVE;
            cx_r       <= 8'd0;
            cy_r       <= 7'd0;
            ptr_r      <= 1'b0;
            plot       <= 1'b0;
            x_out      <= 8'd0;
            y_out      <= 7'd0;
            colour_out <= 3'b000;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            state_r    <= state_s;
            cx_r       <= cx_s;
            cy_r       <= cy_s;
            ptr_r      <= ptr_s;
            plot       <= pix_valid_s;
            x_out      <= pix_x_s;
            y_out      <= pix_y_s;
            colour_out <= pix_c_s;
            clear_busy <= busy_s;
            clear_done <= last_s;
        end
    end

endmodule

// File: tb/tb_plot_arbiter.sv
// Cycle-stepped randomized bench for plot_arbiter, checked against a
// screen-index based reference model.
module tb_plot_arbiter;

    localparam int W = 160;
    localparam int H = 120;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear_start;
    logic       snake_req;
    logic [7:0] snake_x;
    logic [6:0] snake_y;
    logic [2:0] snake_colour;
    logic       food_req;
    logic [7:0] food_x;
    logic [6:0] food_y;
    logic [2:0] food_colour;
    logic       snake_ack, food_ack, plot, clear_busy, clear_done;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;

    int checks = 0;
    int errors = 0;

    // model state
    bit m_clearing = 0;
    int m_idx = 0;
    bit m_ptr = 0;
    int e_plot = 0, e_x = 0, e_y = 0, e_c = 0, e_busy = 0, e_done = 0;
    int done_count;

    plot_arbiter dut (
        .clk(clk), .rst(rst), .clear_start(clear_start),
        .snake_req(snake_req), .snake_x(snake_x), .snake_y(snake_y),
        .snake_colour(snake_colour),
        .food_req(food_req), .food_x(food_x), .food_y(food_y),
        .food_colour(food_colour),
        .snake_ack(snake_ack), .food_ack(food_ack),
        .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
        .plot(plot), .clear_busy(clear_busy), .clear_done(clear_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: check acks mid-cycle, advance model, check outputs after the edge.
    task automatic step();
        int es, ef, wx, wy, wc;
        bit win_snake;
        #3;
        es = 0; ef = 0;
        if (rst) begin
            m_clearing = 0; m_idx = 0; m_ptr = 0;
            e_plot = 0; e_x = 0; e_y = 0; e_c = 0; e_busy = 0; e_done = 0;
        end else if (m_clearing) begin
            e_plot = 1; e_x = m_idx % W; e_y = m_idx / W; e_c = 0;
            e_done = (m_idx == W * H - 1);
            if (e_done) m_clearing = 0;
            else m_idx++;
            e_busy = m_clearing;
        end else if (clear_start) begin
            m_clearing = 1; m_idx = 0;
            e_plot = 0; e_busy = 1; e_done = 0;
        end else begin
            e_plot = 0; e_busy = 0; e_done = 0;
            if (snake_req || food_req) begin
                if (snake_req && food_req) begin
                    win_snake = (m_ptr == 0);
                    m_ptr = ~m_ptr;
                end else begin
                    win_snake = snake_req;
                end
                if (win_snake) begin
                    es = 1; wx = snake_x; wy = snake_y; wc = snake_colour;
                end else begin
                    ef = 1; wx = food_x; wy = food_y; wc = food_colour;
                end
                if (wx < W && wy < H) begin
                    e_plot = 1; e_x = wx; e_y = wy; e_c = wc;
                end
            end
        end
        chk("snake_ack", int'(snake_ack), es);
        chk("food_ack", int'(food_ack), ef);
        @(posedge clk);
        #1;
        chk("plot", int'(plot), e_plot);
        chk("x_out", int'(x_out), e_x);
        chk("y_out", int'(y_out), e_y);
        chk("colour_out", int'(colour_out), e_c);
        chk("clear_busy", int'(clear_busy), e_busy);
        chk("clear_done", int'(clear_done), e_done);
        if (clear_done) done_count++;
    endtask

    task automatic idle();
        rst = 0; clear_start = 0; snake_req = 0; food_req = 0;
    endtask

    initial begin
        idle();
        snake_x = 8'd0; snake_y = 7'd0; snake_colour = 3'd0;
        food_x = 8'd0; food_y = 7'd0; food_colour = 3'd0;
        @(posedge clk); #1;

        // reset, with requests pending to confirm acks stay low
        rst = 1; snake_req = 1; food_req = 1;
        step(); step();
        idle(); step();

        // single snake pixel
        snake_req = 1; snake_x = 8'd10; snake_y = 7'd20; snake_colour = 3'b010;
        step();
        idle(); step();
        chk("req037_x", int'(x_out), 10);

        // contested requests after reset: snake, food, snake, food
        rst = 1; step(); idle();
        snake_req = 1; food_req = 1;
        snake_x = 8'd1; snake_y = 7'd2; snake_colour = 3'b001;
        food_x = 8'd3; food_y = 7'd4; food_colour = 3'b100;
        repeat (4) step();
        idle(); step();

        // off-screen pixels are consumed but dropped
        food_req = 1; food_x = 8'd160; food_y = 7'd5; food_colour = 3'b111;
        step();
        idle(); food_req = 0;
        snake_req = 1; snake_x = 8'd3; snake_y = 7'd120;
        step();
        snake_x = 8'd159; snake_y = 7'd119; snake_colour = 3'b101;
        step();
        idle(); step();

        // random traffic near the screen edges
        for (int i = 0; i < 300; i++) begin
            snake_req = 1'($urandom); food_req = 1'($urandom);
            snake_x = 8'($urandom_range(150, 170)); snake_y = 7'($urandom_range(110, 127));
            food_x = 8'($urandom_range(0, 200)); food_y = 7'($urandom);
            snake_colour = 3'($urandom); food_colour = 3'($urandom);
            step();
        end
        idle(); step();

        // full clear with snake held, second clear_start at sweep pixel 100
        done_count = 0;
        snake_req = 1; snake_x = 8'd7; snake_y = 7'd8; snake_colour = 3'b011;
        for (int i = 0; i < W * H + 4; i++) begin
            clear_start = (i == 0) || (i == 101);
            step();
        end
        clear_start = 0;
        chk("clear_done_once", done_count, 1);
        idle(); step();

        // reset aborts a sweep at pixel 500
        done_count = 0;
        for (int i = 0; i < 520; i++) begin
            clear_start = (i == 0);
            rst = (i == 501);
            step();
        end
        idle();
        repeat (3) step();
        chk("abort_no_done", done_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/plot_arbiter.md
PLOT_ARBITER -- requirements
Module: plot_arbiter

Parameters
REQ-001 SHALL provide WIDTH, default 160, screen width in pixels.
REQ-002 SHALL provide HEIGHT, default 120, screen height in pixels.
REQ-003 SHALL provide CLEAR_COLOUR, default 3'b000, colour used for screen clear.

Interface
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 clear_start  input  1  one-cycle request to clear the whole screen.
REQ-007 snake_req  input  1  snake writer has a pixel pending.
REQ-008 snake_x / snake_y / snake_colour  input  8/7/3  snake pixel data, stable while snake_req is high.
REQ-009 food_req  input  1  food writer has a pixel pending.
REQ-010 food_x / food_y / food_colour  input  8/7/3  food pixel data, stable while food_req is high.
REQ-011 snake_ack / food_ack  output  1 each  combinational grant; pixel consumed at the end of this cycle.
REQ-012 x_out / y_out / colour_out  output  8/7/3  registered VGA write coordinates and colour.
REQ-013 plot  output  1  registered VGA write enable.
REQ-014 clear_busy  output  1  registered; high while a clear sweep is in progress.
REQ-015 clear_done  output  1  registered one-cycle pulse at the end of a clear sweep.

Function
REQ-016 SHALL have two states: SERVE and CLEAR.
REQ-017 In SERVE, clear_start=1 SHALL move the block to CLEAR at the next edge, with the sweep counter at x=0, y=0; no ack is asserted in that cycle.
REQ-018 In CLEAR, each cycle SHALL issue exactly one pixel (counter x, counter y, CLEAR_COLOUR), with plot=1 on the following cycle.
REQ-019 Sweep order SHALL be x fastest: x 0..WIDTH-1, then x wraps to 0 and y increments, through y=HEIGHT-1.
REQ-020 After pixel (WIDTH-1, HEIGHT-1) is issued, the block SHALL return to SERVE; clear_done pulses in the same cycle that pixel appears with plot=1.
REQ-021 A full sweep SHALL take exactly WIDTH*HEIGHT issue cycles (19200 at defaults).
REQ-022 clear_busy SHALL be 1 from the cycle after clear_start is accepted through the cycle the last clear pixel is issued.
REQ-023 clear_start while in CLEAR SHALL be ignored; the sweep is not restarted.
REQ-024 snake_ack and food_ack SHALL both be 0 throughout CLEAR; requesters hold their data.
REQ-025 In SERVE with exactly one request high, that requester SHALL be acked in the same cycle.
REQ-026 In SERVE with both requests high, grant SHALL be round-robin: a 1-bit pointer selects the winner and toggles to the other requester after each contested grant.
REQ-027 Uncontested grants SHALL leave the pointer unchanged.
REQ-028 At most one ack SHALL be high in any cycle.
REQ-029 An acked pixel SHALL appear on x_out/y_out/colour_out with plot=1 exactly one cycle after the ack.
REQ-030 An acked pixel with x>=WIDTH or y>=HEIGHT SHALL be consumed (ack=1) but dropped: plot=0 in the following cycle.
REQ-031 With no grant and no clear pixel issued, plot SHALL be 0 in the following cycle, and x_out/y_out/colour_out SHALL hold their previous values.
REQ-032 A clear_start that coincides with pending requests SHALL take priority: no ack in that cycle.
REQ-033 Counter arithmetic SHALL use 8-bit x and 7-bit y; sweep termination SHALL compare against WIDTH-1 and HEIGHT-1 only, with no wrap beyond.

Reset
REQ-034 rst=1 at a clock edge SHALL force SERVE, plot=0, x_out=0, y_out=0, colour_out=0, clear_busy=0, clear_done=0, sweep counter=0, and the pointer to favour snake.
REQ-035 Reset during CLEAR SHALL abort the sweep immediately; no clear_done is produced.
REQ-036 Acks SHALL be 0 in any cycle where rst=1.

Verification
REQ-037 Reset, then snake_req=1 with (10,20,3'b010) for one cycle -> snake_ack=1 that cycle; next cycle plot=1, x_out=10, y_out=20, colour_out=010.
REQ-038 Both requests held high for 4 cycles after reset -> acks snake, food, snake, food; plot=1 for 4 consecutive cycles starting one cycle later.
REQ-039 clear_start pulse with snake_req held high -> no snake_ack for 19200+1 cycles; plot=1 on 19200 consecutive cycles with colour 000; last pixel (159,119) coincides with clear_done=1; snake_ack resumes the cycle after the last issue.
REQ-040 food_req with (160,5) -> food_ack=1; next cycle plot=0.
REQ-041 rst asserted at sweep pixel 500 -> next cycle clear_busy=0, plot=0; no clear_done follows.
REQ-042 A second clear_start at sweep pixel 100 -> sweep continues; clear_done occurs exactly once, at the original end time.
